// File: rtl/div_seq.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Stalls the execute stage while iterating and pulses done for one cycle with the result.
//
// state | meaning
// IDLE  | waiting for a divide-class start
// CALC  | one shift-subtract step per cycle, counter runs WIDTH-1..0
// FIX   | apply quotient/remainder signs, load result
// DONE  | done pulse, result valid, pipeline released
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, state_n;

   logic             want_rem;
   logic             q_neg;
   logic             r_neg;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH-1:0] rem;
   logic [CW-1:0]    cnt;

   logic             accept;
   logic             op_signed;
   logic             div_zero;
   logic             overflow;
   logic             special;
   logic [WIDTH-1:0] abs1;
   logic [WIDTH-1:0] abs2;
   logic [WIDTH-1:0] special_val;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             fits;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   always_comb begin
      op_signed   = ~funct3[0];
      accept      = (state == IDLE) && start && funct3[2] && !flush;
      div_zero    = (rs2 == '0);
      overflow    = op_signed && (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2 == '1);
      special     = div_zero || overflow;
      abs1        = (op_signed && rs1[WIDTH-1]) ? -rs1 : rs1;
      abs2        = (op_signed && rs2[WIDTH-1]) ? -rs2 : rs2;
      if (div_zero)
         special_val = funct3[1] ? rs1 : '1;
      else
         special_val = funct3[1] ? '0 : rs1;

      // remainder stays below the divisor, so a borrow out of diff means "does not fit"
      shifted     = {rem, quo[WIDTH-1]};
      diff        = shifted - {1'b0, dvsr};
      fits        = ~diff[WIDTH];

      quo_fix     = q_neg ? -quo : quo;
      rem_fix     = r_neg ? -rem : rem;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (accept) state_n = special ? DONE : CALC;
         CALC: if (cnt == '0) state_n = FIX;
         FIX:  state_n = DONE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (flush && (state != IDLE))
         state_n = IDLE;
   end

   assign stall = ((state == IDLE) && start && funct3[2]) || (state == CALC) || (state == FIX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         want_rem <= 1'b0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         quo      <= '0;
         dvsr     <= '0;
         rem      <= '0;
         cnt      <= '0;
      end else begin
         state <= state_n;
         busy  <= (state_n == CALC) || (state_n == FIX);
         done  <= (state_n == DONE);

         if (accept) begin
            want_rem <= funct3[1];
            q_neg    <= op_signed && (rs1[WIDTH-1] ^ rs2[WIDTH-1]);
            r_neg    <= op_signed && rs1[WIDTH-1];
            if (special) begin
               result <= special_val;
            end else begin
               quo  <= abs1;
               dvsr <= abs2;
               rem  <= '0;
               cnt  <= CW'(WIDTH - 1);
            end
         end

         if ((state == CALC) && !flush) begin
            rem <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], fits};
            cnt <= cnt - CW'(1);
         end

         if ((state == FIX) && !flush)
            result <= want_rem ? rem_fix : quo_fix;
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: arithmetic reference model with a per-cycle compare process,
// plus literal expectations for the documented cases.
module tb_div_seq;

   localparam int W   = 32;
   localparam int LAT = W + 1;   // cycles from acceptance edge to the done cycle

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    funct3 = 3'b000;
   logic [W-1:0]  rs1 = '0;
   logic [W-1:0]  rs2 = '0;
   logic          flush = 1'b0;
   logic          stall, busy, done;
   logic [W-1:0]  result;

   div_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3),
      .rs1(rs1), .rs2(rs2), .flush(flush),
      .stall(stall), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // RISC-V M-extension divide semantics in plain arithmetic
   function automatic logic [W-1:0] model(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [W-1:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 0) return f3[1] ? a : {W{1'b1}};
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return f3[1] ? 32'h0 : 32'h8000_0000;
      if (!f3[0]) return f3[1] ? W'(sa % sb) : W'(sa / sb);
      return f3[1] ? (a % b) : (a / b);
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // model state: an op in flight accepted at the edge that starts cycle m_acc
   bit           m_live = 1'b0;
   int           m_acc  = 0;
   int           m_lat  = 0;
   logic [W-1:0] m_val  = '0;
   logic [W-1:0] m_prev = '0;

   int           k;
   logic         e_busy, e_done, e_stall;
   logic [W-1:0] e_res;

   always @(negedge clk) begin
      k = m_live ? (cyc - m_acc) : -1;
      e_busy = m_live && k >= 0 && k < m_lat;
      e_done = m_live && k == m_lat;
      e_res  = (m_live && k >= m_lat) ? m_val : m_prev;
      e_stall = e_busy || (!(m_live && k >= 0 && k <= m_lat) && start && funct3[2]);
      check("cyc_busy",   W'(busy),  W'(e_busy));
      check("cyc_done",   W'(done),  W'(e_done));
      check("cyc_stall",  W'(stall), W'(e_stall));
      check("cyc_result", result,    e_res);
   end

   // called at posedge+1; returns at posedge+1 of the first idle cycle after done
   task automatic do_op(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] lit, input bit use_lit,
                        input bit spur);
      start  = 1'b1;
      funct3 = f3;
      rs1    = a;
      rs2    = b;
      m_val  = model(f3, a, b);
      m_lat  = is_special(f3, a, b) ? 0 : LAT;
      m_acc  = cyc + 1;
      m_live = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= m_lat; i++) begin
         @(posedge clk); #1;
         if (spur && i == 5) begin
            start = 1'b1; funct3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd10;
         end
         if (spur && i == 8) start = 1'b0;
      end
      check({name, "_done"}, W'(done), W'(1));
      if (use_lit) check(name, result, lit);
      @(posedge clk); #1;
      m_prev = m_val;
      m_live = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",   W'(busy),  W'(0));
      check("rst_done",   W'(done),  W'(0));
      check("rst_stall",  W'(stall), W'(0));
      check("rst_result", result,    W'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 1, 0);
      do_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 1, 0);
      do_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1, 0);
      do_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, 0);
      do_op("div_5_0",    3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
      do_op("remu_5_0",   3'b111, 32'd5, 32'd0, 32'd5, 1, 0);
      do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
      do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);
      do_op("div_7_m2",   3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1, 0);
      do_op("rem_7_m2",   3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1, 0);
      do_op("divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1, 0);
      do_op("m_div",      3'b100, 32'hFFFF_FF9C, 32'd7, 32'h0, 0, 0);
      do_op("m_rem",      3'b110, 32'hFFFF_FF9C, 32'd7, 32'h0, 0, 0);
      do_op("m_divu",     3'b101, 32'hDEAD_BEEF, 32'h0001_2345, 32'h0, 0, 0);
      do_op("m_remu",     3'b111, 32'hDEAD_BEEF, 32'h0001_2345, 32'h0, 0, 0);
      do_op("m_div_ovfl", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0);

      // start while busy is ignored: result still belongs to the first op
      do_op("busy_ignore", 3'b101, 32'd100, 32'd7, 32'd14, 1, 1);

      // flush during the 10th CALC cycle
      start = 1'b1; funct3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd3;
      m_val = model(3'b101, 32'd1000, 32'd3); m_lat = LAT; m_acc = cyc + 1; m_live = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush  = 1'b0;
      m_live = 1'b0;
      check("flush_busy",  W'(busy),  W'(0));
      check("flush_stall", W'(stall), W'(0));
      check("flush_done",  W'(done),  W'(0));
      repeat (3) begin @(posedge clk); #1; end
      do_op("after_flush", 3'b101, 32'd9, 32'd3, 32'd3, 1, 0);

      // asynchronous reset mid-CALC
      start = 1'b1; funct3 = 3'b101; rs1 = 32'd500; rs2 = 32'd7;
      m_val = model(3'b101, 32'd500, 32'd7); m_lat = LAT; m_acc = cyc + 1; m_live = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      m_live = 1'b0;
      m_prev = '0;
      #1;
      check("arst_busy",   W'(busy),  W'(0));
      check("arst_done",   W'(done),  W'(0));
      check("arst_stall",  W'(stall), W'(0));
      check("arst_result", result,    W'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // non-divide funct3 never stalls or starts
      start = 1'b1; funct3 = 3'b000; rs1 = 32'd10; rs2 = 32'd2;
      #1;
      check("f3_000_stall", W'(stall), W'(0));
      @(posedge clk); #1;
      check("f3_000_busy", W'(busy), W'(0));
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end

      do_op("final_divu", 3'b101, 32'd100, 32'd7, 32'd14, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative multi-cycle divider sequencer for the RV32M DIV/DIVU/REM/REMU instructions in the pipelined CPU's execute stage. It accepts an operation when the ALU control decodes a divide-class funct3 with funct7[25] set. It stalls the pipeline while a restoring shift-subtract loop runs, then presents a one-cycle result for the stage to capture. RISC-V special cases (divide by zero, signed overflow) complete early without iterating.

## Interface
- WIDTH, 32: operand and result width; iteration counter is clog2(WIDTH) bits.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request from the execute stage; qualified by funct3[2]=1.
- funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; captured at acceptance.
- rs1  in  WIDTH  dividend, captured at acceptance.
- rs2  in  WIDTH  divisor, captured at acceptance.
- flush  in  1  synchronous abort from hazard/branch logic.
- stall  out  1  combinational; holds IF/ID/EX while a divide is outstanding.
- busy  out  1  registered; high in CALC and FIX.
- done  out  1  registered one-cycle pulse; result valid this cycle.
- result  out  WIDTH  quotient or remainder; holds until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Acceptance: IDLE and start=1 and funct3[2]=1. Starts with funct3[2]=0 and starts outside IDLE are ignored.
- On acceptance, latch op (signed = ~funct3[0], want_rem = funct3[1]).
- Divisor==0: next state DONE; result = all ones for DIV/DIVU, rs1 for REM/REMU.
- Signed op with rs1=0x8000_0000 and rs2=0xFFFF_FFFF: next state DONE; result = 0x8000_0000 for DIV, 0 for REM.
- Otherwise:
  - Load |rs1| (or rs1 if unsigned) into the quotient shift register.
  - Load |rs2| into the divisor register, clear the WIDTH+1-bit partial remainder, set counter = WIDTH-1, go to CALC.
- CALC, each cycle:
  - rem' = {rem[WIDTH-1:0], q[WIDTH-1]}, q shifts left.
  - If rem' >= divisor: rem' -= divisor and the q LSB gets 1, else 0.
  - Counter decrements; at counter 0 go to FIX.
- FIX:
  - Quotient is negated if signed and the operand signs differ.
  - Remainder takes the dividend's sign (negated if signed and rs1 negative).
  - Select quotient or remainder into result and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - A start seen in DONE is ignored; the stage restarts it after stall drops.
- stall = (IDLE and start and funct3[2]) or CALC or FIX. Stall is low in DONE, so the pipeline advances and captures result that cycle.
- flush, in any state other than IDLE:
  - Next state IDLE, done stays 0, result unchanged.
  - Flush takes priority over acceptance in the same cycle.
- rst: state IDLE, busy=0, done=0, result=0, counter=0, internal registers 0. Applies immediately, including mid-operation.

## Timing
- Normal op latency: start accepted at edge 0; CALC occupies cycles 1..WIDTH; FIX in cycle WIDTH+1; done in cycle WIDTH+2 (34 for WIDTH=32).
- Special case: done in cycle 1 after acceptance.
- stall is high from the acceptance cycle through FIX inclusive, and low in DONE.
- Back-to-back: the next start is accepted in the IDLE cycle after DONE at earliest.
- Minimum spacing is therefore WIDTH+3 cycles for normal ops and 2 cycles for special cases.

## Test plan
- DIVU rs1=100, rs2=7: stall high 34 cycles; done at cycle 34; result=14. Repeat as REMU: result=2.
- DIV rs1=-7 (0xFFFF_FFF9), rs2=2: result=0xFFFF_FFFD (-3). REM same operands: result=0xFFFF_FFFF (-1).
- DIV rs1=5, rs2=0: done at cycle 1; result=0xFFFF_FFFF. REMU rs1=5, rs2=0: result=5.
- DIV 0x8000_0000 / 0xFFFF_FFFF: result=0x8000_0000 at cycle 1. REM same operands: result=0.
- Start DIVU, assert flush in CALC cycle 10: no done pulse; busy=0 and stall=0 next cycle; a new DIVU 9/3 then yields 3 after 34 cycles.
- Assert rst during CALC: busy, done, stall and result read 0 immediately. Also: start asserted while busy is ignored (the result matches the first operation); start with funct3=000 gives no stall.
